// File: rtl/ptype_fifo.sv
// Type-parameterised elastic FIFO: DEPTH-entry circular buffer, valid/ready on both sides, 1-cycle first-word latency.
// Backpressure via a_ready=!full; define PTYPE_FIFO_BYPASS_EN for same-cycle fall-through when empty.
module ptype_fifo #(
  parameter int  WIDTH  = 1,
  parameter type TYPE_T = logic [WIDTH-1:0],
  parameter int  DEPTH  = 4,
  parameter int  CNT_W  = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  TYPE_T            a,
  input  logic             a_valid,
  output logic             a_ready,
  output TYPE_T            y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  TYPE_T              mem [DEPTH];

  logic push, pop, bypass, wr_en, rd_en;

  assign empty   = (state_q == EMPTY);
  assign full    = (state_q == FULL);
  assign a_ready = !full;
  assign count   = count_q;

`ifdef PTYPE_FIFO_BYPASS_EN
  // Empty FIFO presents the producer directly; a same-cycle accept skips storage.
  assign y_valid = empty ? a_valid : 1'b1;
  assign bypass  = empty && a_valid && y_ready;
  always_comb begin
    y = mem[rd_ptr_q];
    if (empty) y = a;
  end
`else
  assign y_valid = !empty;
  assign bypass  = 1'b0;
  always_comb begin
    y = '0;
    if (!empty) y = mem[rd_ptr_q];
  end
`endif

  assign push  = a_valid && a_ready;
  assign pop   = y_valid && y_ready;
  assign wr_en = push && !bypass;
  assign rd_en = pop && !bypass;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= a;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;

    if (wr_en) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_q + PTR_W'(1);
    if (rd_en) rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_q + PTR_W'(1);

    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Simultaneous push and pop leaves occupancy, hence state, unchanged.
    case (state_q)
      EMPTY:   if (wr_en) state_d = PARTIAL;
      PARTIAL: begin
        if (wr_en && !rd_en && count_q == CNT_W'(DEPTH-1))
          state_d = FULL;
        else if (rd_en && !wr_en && count_q == CNT_W'(1))
          state_d = EMPTY;
      end
      FULL:    if (rd_en) state_d = PARTIAL;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_ptype_fifo.sv
// Directed and randomized checks of ptype_fifo across byte, DEPTH=3 and struct payload instances.
module tb_ptype_fifo;

  typedef struct packed {logic [3:0] id; logic [11:0] d;} pkt_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

`ifdef PTYPE_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // DUT0: DEPTH=4, 8-bit
  logic [7:0] a0, y0;
  logic a0_v, a0_r, y0_v, y0_r, full0, empty0;
  logic [2:0] cnt0;
  // DUT1: DEPTH=3, 8-bit
  logic [7:0] a1, y1;
  logic a1_v, a1_r, y1_v, y1_r, full1, empty1;
  logic [1:0] cnt1;
  // DUT2: DEPTH=4, struct payload
  pkt_t a2, y2;
  logic a2_v, a2_r, y2_v, y2_r, full2, empty2;
  logic [2:0] cnt2;

  ptype_fifo #(.WIDTH(8), .DEPTH(4)) u0 (
    .clk(clk), .rst_n(rst_n), .a(a0), .a_valid(a0_v), .a_ready(a0_r),
    .y(y0), .y_valid(y0_v), .y_ready(y0_r), .count(cnt0), .full(full0), .empty(empty0));
  ptype_fifo #(.WIDTH(8), .DEPTH(3)) u1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .a_valid(a1_v), .a_ready(a1_r),
    .y(y1), .y_valid(y1_v), .y_ready(y1_r), .count(cnt1), .full(full1), .empty(empty1));
  ptype_fifo #(.TYPE_T(pkt_t), .DEPTH(4)) u2 (
    .clk(clk), .rst_n(rst_n), .a(a2), .a_valid(a2_v), .a_ready(a2_r),
    .y(y2), .y_valid(y2_v), .y_ready(y2_r), .count(cnt2), .full(full2), .empty(empty2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] got[$];
  logic [7:0] mq[$];
  logic [7:0] exp_list[$];

  initial begin
    logic       e_yv, e_push, e_pop;
    logic [7:0] e_y;

    rst_n = 1'b0;
    a0 = '0; a0_v = 0; y0_r = 0;
    a1 = '0; a1_v = 0; y1_r = 0;
    a2 = '0; a2_v = 0; y2_r = 0;
    #1;
    chk("rst_empty", 32'(empty0), 32'd1);
    chk("rst_full", 32'(full0), 32'd0);
    chk("rst_count", 32'(cnt0), 32'd0);
    chk("rst_yvalid", 32'(y0_v), 32'd0);
    chk("rst_aready", 32'(a0_r), 32'd1);
    chk("rst_y", 32'(y0), 32'h00);
    #20 rst_n = 1'b1;
    tick();
    chk("idle_empty", 32'(empty0), 32'd1);
    chk("idle_y", 32'(y0), 32'h00);

    // Fill to full, then an extra push is dropped
    for (int i = 1; i <= 4; i++) begin
      a0 = 8'(8'h11 * i); a0_v = 1;
      tick();
    end
    chk("fill_full", 32'(full0), 32'd1);
    chk("fill_aready", 32'(a0_r), 32'd0);
    chk("fill_count", 32'(cnt0), 32'd4);
    a0 = 8'h55;
    tick();
    chk("drop_count", 32'(cnt0), 32'd4);
    a0_v = 0; y0_r = 1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", 32'(y0), 32'(8'h11 * i));
      tick();
    end
    chk("drain_empty", 32'(empty0), 32'd1);
    chk("drain_yvalid", 32'(y0_v), 32'd0);

    // Full with simultaneous push/pop: only the pop happens
    y0_r = 0;
    for (int i = 1; i <= 4; i++) begin
      a0 = 8'(i); a0_v = 1;
      tick();
    end
    chk("full2_count", 32'(cnt0), 32'd4);
    a0 = 8'hAA; a0_v = 1; y0_r = 1;
    chk("full2_head", 32'(y0), 32'h01);
    tick();
    chk("full2_popcnt", 32'(cnt0), 32'd3);
    y0_r = 0;
    tick();
    chk("full2_retry", 32'(cnt0), 32'd4);
    a0_v = 0; y0_r = 1;
    exp_list = '{8'h02, 8'h03, 8'h04, 8'hAA};
    foreach (exp_list[i]) begin
      chk("full2_order", 32'(y0), 32'(exp_list[i]));
      tick();
    end
    chk("full2_empty", 32'(empty0), 32'd1);

    // Partial: push and pop each cycle, count stays 2
    y0_r = 0;
    for (int i = 0; i < 2; i++) begin
      a0 = 8'(8'hB0 + i); a0_v = 1;
      tick();
    end
    chk("part_count", 32'(cnt0), 32'd2);
    for (int i = 0; i < 5; i++) begin
      a0 = 8'(8'hB2 + i); a0_v = 1; y0_r = 1;
      chk("part_head", 32'(y0), 32'(8'hB0 + i));
      tick();
      chk("part_count", 32'(cnt0), 32'd2);
    end
    a0_v = 0;
    for (int i = 0; i < 2; i++) begin
      chk("part_tail", 32'(y0), 32'(8'hB5 + i));
      tick();
    end
    chk("part_empty", 32'(empty0), 32'd1);
    y0_r = 0;

    // DEPTH=3 streaming through pointer wrap
    y1_r = 1;
    for (int i = 1; i <= 12; i++) begin
      a1 = 8'(i); a1_v = (i <= 10);
      if (y1_v && y1_r) got.push_back(y1);
      tick();
      chk("wrap_cnt_le1", 32'(cnt1 <= 2'd1), 32'd1);
    end
    a1_v = 0;
    chk("wrap_n", 32'(got.size()), 32'd10);
    foreach (got[i]) chk("wrap_order", 32'(got[i]), 32'(i + 1));

    // Randomized traffic against a queue model
    for (int c = 0; c < 400; c++) begin
      a0 = 8'($urandom);
      a0_v = 1'($urandom_range(0, 1));
      y0_r = ($urandom_range(0, 3) != 0);
      #1;
      e_yv = (mq.size() != 0) || (BYP && a0_v);
      e_y  = (mq.size() != 0) ? mq[0] : (BYP ? a0 : 8'h00);
      chk("rnd_yvalid", 32'(y0_v), 32'(e_yv));
      chk("rnd_y", 32'(y0), 32'(e_y));
      chk("rnd_count", 32'(cnt0), 32'(mq.size()));
      chk("rnd_full", 32'(full0), 32'(mq.size() == 4));
      chk("rnd_aready", 32'(a0_r), 32'(mq.size() < 4));
      e_push = a0_v && (mq.size() < 4);
      e_pop  = e_yv && y0_r;
      @(posedge clk);
      if (!(mq.size() == 0 && e_push && e_pop)) begin
        if (e_pop) void'(mq.pop_front());
        if (e_push) mq.push_back(a0);
      end
      #1;
    end
    a0_v = 0; y0_r = 0;

    // Struct payload: async reset mid-cycle discards contents
    for (int i = 1; i <= 3; i++) begin
      a2 = '{id: 4'(i), d: 12'(i * 12'h111)}; a2_v = 1;
      tick();
    end
    a2_v = 0; a2 = '0;
    chk("st_count3", 32'(cnt2), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("st_rst_empty", 32'(empty2), 32'd1);
    chk("st_rst_y", 32'(y2), 32'h0);
    chk("st_rst_count", 32'(cnt2), 32'd0);
    chk("st_rst_yvalid", 32'(y2_v), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    a2 = '{id: 4'h5, d: 12'hABC}; a2_v = 1;
    #1;
    chk("st_same_yvalid", 32'(y2_v), 32'(BYP));
    if (BYP) chk("st_same_y", 32'(y2), 32'h5ABC);
    tick();
    a2_v = 0;
    chk("st_next_yvalid", 32'(y2_v), 32'd1);
    chk("st_next_y", 32'(y2), 32'h5ABC);
    chk("st_next_count", 32'(cnt2), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ptype_fifo.md
Name: ptype_fifo

Overview:
- Type-parameterised, elastic successor to the plain type-parameterised buffer.
- Carries one TYPE_T item per transfer through a DEPTH-entry circular FIFO, with valid/ready handshakes on both sides.
- Default TYPE_T is logic [WIDTH-1:0], so instances that override only WIDTH still work.
- Sits between producer/consumer stages that exchange typedef'd payloads (foo_t, struct types) and need decoupling and backpressure.

Parameters:
- WIDTH, 1: payload width used only by the default TYPE_T.
- type TYPE_T, logic [WIDTH-1:0]: payload type; any packed type.
- DEPTH, 4: number of entries; legal range 2..256; need not be a power of two.
- CNT_W, $clog2(DEPTH+1): width of count; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- a  input  TYPE_T  write payload.
- a_valid  input  1  write request.
- a_ready  output  1  FIFO can accept; equals !full.
- y  output  TYPE_T  head payload.
- y_valid  output  1  head is valid; equals !empty.
- y_ready  input  1  consumer accepts head.
- count  output  CNT_W  occupied entries, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr=0, rd_ptr=0, count=0, state=EMPTY.
  - Outputs during reset: empty=1, full=0, y_valid=0, a_ready=1, y='0.
  - Storage array is not reset.
- Push = a_valid && a_ready. Pop = y_valid && y_ready. Both are sampled at the rising edge.
- Push writes a into mem[wr_ptr]. wr_ptr then increments, wrapping explicitly from DEPTH-1 to 0. rd_ptr behaves the same way on pop.
- Latency: an item pushed at edge N is visible on y with y_valid=1 after edge N (first-word latency 1 cycle). No combinational path from a to y.
- y = mem[rd_ptr] when !empty, else '0. y is stable while y_valid && !y_ready.
- State machine (registered, derived with count):
  - EMPTY -> PARTIAL on push.
  - PARTIAL -> FULL on push without pop when count==DEPTH-1.
  - PARTIAL -> EMPTY on pop without push when count==1.
  - FULL -> PARTIAL on pop.
  - Push and pop in the same cycle leave state and count unchanged.
- Simultaneous push and pop:
  - In PARTIAL: both occur, count unchanged, both pointers advance.
  - When full: a_ready=0, so only the pop occurs; the push is retried next cycle.
  - When empty: only the push occurs (y_valid=0, so no pop).
- a_valid while full: ignored, no state change. Producer must hold a stable until a_ready.
- y_ready while empty: ignored.
- count arithmetic is CNT_W-bit unsigned; never exceeds DEPTH and never underflows.
- Reset asserted mid-operation: all contents are discarded immediately. Outputs take reset values asynchronously, regardless of clk.

Optional Feature:
- Macro: PTYPE_FIFO_BYPASS_EN.
- When defined, the FIFO has fall-through bypass when empty:
  - y = a and y_valid = a_valid combinationally.
  - If y_ready is also 1, the item transfers in the same cycle and is not stored (count stays 0).
  - If y_ready is 0, the item is stored normally.
  - Outside the empty state, behaviour is identical to the non-bypass build.
- When undefined: no a->y combinational path, first-word latency 1 cycle as above.

Test Plan:
- Reset then idle, DEPTH=4, TYPE_T=logic[7:0]: required empty=1, full=0, count=0, y_valid=0, a_ready=1, y=8'h00.
- Push 8'h11,22,33,44 with y_ready=0: required full=1 and a_ready=0 after the 4th edge. A 5th push of 8'h55 is dropped. Popping then returns 11,22,33,44 in order and empty=1.
- DEPTH=3 wrap check: push/pop 10 items 8'h01..8'h0A with y_ready=1 every cycle: required output order 01..0A, count <= 1 throughout, pointers wrap 2->0 without a gap.
- Full plus simultaneous push/pop, count=4: a_valid=1 (8'hAA) and y_ready=1: required pop of head only, count=3. Next cycle AA is accepted, count=4.
- PARTIAL count=2, push and pop in the same cycle for 5 cycles: required count stays 2, output order preserved.
- TYPE_T=struct packed {logic[3:0] id; logic[11:0] d;}, reset pulsed while count=3: required immediate empty=1, y='0. Post-reset push of {4'h5,12'hABC} appears on y the next cycle. With PTYPE_FIFO_BYPASS_EN it appears on y the same cycle.
